// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: state encoding,
// baud divisor calculation and the 2-of-3 vote used by majority sampling.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  function automatic int unsigned bps_cnt(input int unsigned clk_freq,
                                          input int unsigned uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_recv_if.sv
// Received-byte bus: the receiver drives it (master), the byte consumer
// (command parser / DRAM test controller) observes it (slave).
interface uart_recv_if;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       frame_err;
  logic       rx_busy;

  modport master (output uart_data, output uart_done, output frame_err, output rx_busy);
  modport slave  (input  uart_data, input  uart_done, input  frame_err, input  rx_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin plus a delayed copy
// used to detect the falling edge that marks a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic sys_rst_n,
  input  logic uart_rxd,
  output logic rxd_sync,
  output logic start_edge
);

  logic rxd_s1;
  logic rxd_s2;
  logic rxd_s3;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_s3 <= 1'b1;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
    end
  end

  assign rxd_sync   = rxd_s2;
  assign start_edge = rxd_s3 & ~rxd_s2;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: centre-sampled data bits, stop-bit check, one-cycle
// done / frame-error strobes. Define UART_RX_MAJORITY_EN for 2-of-3 sampling.
module uart_recv
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic clk,
  input  logic sys_rst_n,
  input  logic uart_rxd,
  uart_recv_if.master rx
);

  localparam int unsigned BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [15:0] BIT_END = 16'(BPS_CNT - 1);

  logic rxd_sync;
  logic start_edge;
  logic sample;

  uart_rx_sync u_sync (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .uart_rxd   (uart_rxd),
    .rxd_sync   (rxd_sync),
    .start_edge (start_edge)
  );

`ifdef UART_RX_MAJORITY_EN
  // Voting one count late in START shifts the whole frame by one clock, so the
  // later decisions at BIT_END still see a window centred on each bit.
  localparam logic [15:0] START_END = 16'(BPS_CNT / 2);

  logic [1:0] hist;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) hist <= '1;
    else            hist <= {hist[0], rxd_sync};
  end

  assign sample = maj3(hist[1], hist[0], rxd_sync);
`else
  localparam logic [15:0] START_END = 16'(BPS_CNT / 2 - 1);

  assign sample = rxd_sync;
`endif

  rx_state_t   state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 16'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (start_edge) state_d = START;
      end
      START: begin
        if (clk_cnt_q == START_END) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          shift_d   = {sample, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          if (sample) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        clk_cnt_d = '0;
        if (rxd_sync) state_d = IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign rx.uart_data = data_q;
  assign rx.uart_done = done_q;
  assign rx.frame_err = err_q;
  assign rx.rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: directed and random frames compared
// against a frame-level reference model of expected strobes and timing.
module tb_uart_recv;

  localparam int CLK_FREQ = 50000000;
  localparam int UART_BPS = 115200;
  localparam int BPS      = CLK_FREQ / UART_BPS;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_SHIFT = 1;
`else
  localparam int MAJ_SHIFT = 0;
`endif
  localparam int LAT = 3 + BPS / 2 + 9 * BPS + MAJ_SHIFT;

  logic clk       = 1'b0;
  logic sys_rst_n = 1'b0;
  logic uart_rxd  = 1'b1;

  uart_recv_if rx ();

  uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .rx        (rx)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t;
    logic       busy;
  } evt_t;

  evt_t obs_q[$];
  evt_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   both_cnt = 0;
  int   wide_cnt = 0;
  logic done_prev = 1'b0;
  logic err_prev  = 1'b0;
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    if (rx.uart_done && rx.frame_err) both_cnt++;
    if ((rx.uart_done && done_prev) || (rx.frame_err && err_prev)) wide_cnt++;
    if (rx.uart_done)
      obs_q.push_back('{err: 1'b0, data: rx.uart_data, t: cyc, busy: rx.rx_busy});
    else if (rx.frame_err)
      obs_q.push_back('{err: 1'b1, data: rx.uart_data, t: cyc, busy: rx.rx_busy});
    done_prev = rx.uart_done;
    err_prev  = rx.frame_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a well-framed byte yields a done strobe carrying it; a
  // low stop bit yields an error strobe while the last good byte is held.
  function automatic void model(input logic [7:0] b, input logic stop, input int t0, input bit chk_t);
    evt_t e;
    if (stop) last_good = b;
    e.err  = !stop;
    e.data = last_good;
    e.t    = chk_t ? t0 + LAT : -1;
    e.busy = 1'b0;
    exp_q.push_back(e);
  endfunction

  task automatic drive_bits(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int per,
                            input bit spike, input bit chk_t);
    logic [9:0] bits;
    int         t0;
    bits = {stop, b, 1'b0};
    t0   = cyc;
    for (int i = 0; i < 10; i++) begin
      if (spike && i >= 1 && i <= 8) begin
        drive_bits(bits[i], per / 2);
        drive_bits(~bits[i], 1);
        drive_bits(bits[i], per - per / 2 - 1);
      end else begin
        drive_bits(bits[i], per);
      end
    end
    model(b, stop, t0, chk_t);
  endtask

  task automatic compare_events(input string tag);
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_eq({tag, "_kind"}, obs_q[i].err, exp_q[i].err);
      check_eq({tag, "_data"}, obs_q[i].data, exp_q[i].data);
      if (exp_q[i].t >= 0) check_eq({tag, "_time"}, obs_q[i].t, exp_q[i].t);
      if (!exp_q[i].err) check_eq({tag, "_busy"}, obs_q[i].busy, exp_q[i].busy);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         busy_n;
    logic [7:0] pb;
    logic [7:0] rb;
    logic       rs;

    repeat (5) @(negedge clk);
    check_eq("rst_data", rx.uart_data, 8'h00);
    check_eq("rst_done", rx.uart_done, 1'b0);
    check_eq("rst_err",  rx.frame_err, 1'b0);
    check_eq("rst_busy", rx.rx_busy,   1'b0);
    sys_rst_n = 1'b1;
    repeat (10000) @(negedge clk);
    compare_events("idle");
    check_eq("idle_busy", rx.rx_busy, 1'b0);

    send_frame(8'hA5, 1'b1, BPS, 1'b0, 1'b1);
    drive_bits(1'b1, 20);
    compare_events("a5");

    send_frame(8'h00, 1'b1, BPS, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, BPS, 1'b0, 1'b1);
    send_frame(8'h55, 1'b1, BPS, 1'b0, 1'b1);
    drive_bits(1'b1, 20);
    compare_events("b2b");

    send_frame(8'h3C, 1'b0, BPS, 1'b0, 1'b1);
    drive_bits(1'b1, 50);
    send_frame(8'h81, 1'b1, BPS, 1'b0, 1'b1);
    drive_bits(1'b1, 20);
    compare_events("ferr");

    busy_n = 0;
    uart_rxd = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (i == 100) uart_rxd = 1'b1;
      @(negedge clk);
      if (rx.rx_busy) busy_n++;
    end
    check_eq("glitch_busy_seen", busy_n > 0, 1'b1);
    check_eq("glitch_busy_le220", busy_n <= 220, 1'b1);
    compare_events("glitch");

    send_frame(8'hC3, 1'b1, 421, 1'b0, 1'b0);
    drive_bits(1'b1, 20);
    send_frame(8'hC3, 1'b1, 447, 1'b0, 1'b0);
    drive_bits(1'b1, 20);
    compare_events("baud");

    pb = 8'h6B;
    drive_bits(1'b0, BPS);
    for (int i = 0; i < 4; i++) drive_bits(pb[i], BPS);
    drive_bits(pb[4], 100);
    check_eq("rstmid_busy_pre", rx.rx_busy, 1'b1);
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rstmid_busy", rx.rx_busy, 1'b0);
    check_eq("rstmid_data", rx.uart_data, 8'h00);
    sys_rst_n = 1'b1;
    last_good = 8'h00;
    drive_bits(1'b1, 100);
    compare_events("rstmid");
    send_frame(8'h12, 1'b1, BPS, 1'b0, 1'b1);
    drive_bits(1'b1, 20);
    compare_events("post_rst");

    send_frame(8'h00, 1'b0, BPS, 1'b0, 1'b1);
    drive_bits(1'b0, 500);
    drive_bits(1'b1, 20);
    compare_events("break");

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h96, 1'b1, BPS, 1'b1, 1'b1);
    drive_bits(1'b1, 20);
    compare_events("spike");
`endif

    for (int n = 0; n < 3; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, BPS, 1'b0, 1'b1);
      drive_bits(1'b1, rs ? $urandom_range(0, 30) : $urandom_range(10, 40));
    end
    drive_bits(1'b1, 20);
    compare_events("rand");

    check_eq("pulse_overlap", both_cnt, 0);
    check_eq("pulse_width", wide_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
# uart_recv

UART receiver, the receive-side counterpart of the design's 8N1 transmitter, at the same default rate of 115200 baud from a 50 MHz clock. It synchronizes the asynchronous serial input and finds each start bit. It samples 8 data bits LSB-first at bit centres, checks the stop bit, and presents each completed byte with a one-cycle strobe. It sits between the board RX pin and the byte-consuming logic (command parser / DRAM test controller).

## Interface
- CLK_FREQ, 50000000, frequency of clk in Hz
- UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer divide), legal range 16..65535
- clk  input  1  system clock; all logic on rising edge
- sys_rst_n  input  1  reset; asynchronous, active-low; clock is clk
- uart_rxd  input  1  serial line, idle high, asynchronous to clk
- uart_data  output  8  last correctly framed byte; holds until next good byte
- uart_done  output  1  one-cycle pulse, uart_data valid on the same cycle
- frame_err  output  1  one-cycle pulse, stop bit sampled low
- rx_busy  output  1  high from start-bit detection until return to IDLE

## Operation
- Input path: two-flop synchronizer rxd_s1→rxd_s2, then delayed copy rxd_s3; start edge = rxd_s3 & ~rxd_s2.
- clk_cnt: 16-bit, counts 0..BPS_CNT-1 inside a bit, resets to 0 on every state change.
- bit_cnt: 3-bit data-bit index.
- State machine:
  - IDLE: on start edge → START, clk_cnt=0.
  - START: at clk_cnt==BPS_CNT/2-1, sample the line. 0 → DATA, clk_cnt=0, bit_cnt=0. 1 → IDLE (glitch rejected, no output pulse).
  - DATA: at clk_cnt==BPS_CNT-1, shift the sample into shift_reg[7] and shift right (LSB first). Then bit_cnt++, clk_cnt=0. After bit 7 → STOP.
  - STOP: at clk_cnt==BPS_CNT-1, sample the line. 1 → uart_data<=shift_reg, uart_done=1, → IDLE. 0 → frame_err=1, uart_data unchanged, → WAIT_IDLE.
  - WAIT_IDLE: stay until rxd_s2==1, then → IDLE. A held-low line (break) therefore yields exactly one frame_err.
- Because START ends mid-bit, all later samples fall at bit centres.
- IDLE does not re-arm until the stop-bit sample point. A start edge during the second half of the stop bit is therefore missed only if the remote runs more than ½ bit fast; that is acceptable.
- Reset mid-frame: all state returns to reset values immediately. The partial byte is discarded and no pulse is generated.

## Timing
- Reset values: uart_data=8'h00, uart_done=0, frame_err=0, rx_busy=0, state=IDLE, rxd_s1/s2/s3=1.
- Start detection: 3 clk after the uart_rxd falling edge (2 synchronizer + 1 edge register).
- uart_done and frame_err are registered. They assert 3 + BPS_CNT/2 + 9·BPS_CNT clk after the start edge on uart_rxd, ±1 clk.
- uart_done and frame_err never assert together, and each lasts exactly one cycle.
- rx_busy rises the cycle after start detection and falls in the same cycle as uart_done or frame_err. In the WAIT_IDLE case it falls when the line returns high.
- Minimum back-to-back spacing: one stop bit (no extra idle required).

## Configuration
- UART_RX_MAJORITY_EN defined: each sample point (start, data, stop) takes 2-of-3 majority of rxd_s2 at counts target-1, target, target+1. The decision is used at target+1, so output timing shifts +1 clk.
- Undefined: single sample of rxd_s2 at the target count.

## Structure
- Shared package uart_pkg:
  - localparam function for BPS_CNT.
  - state enum IDLE/START/DATA/STOP/WAIT_IDLE (3-bit encoding).
- Sub-module uart_rx_sync: synchronizer plus falling-edge detect; outputs rxd_sync and start_edge.
- FSM, counters and shift register live in uart_recv.

## Test plan
Defaults throughout (BPS_CNT=434).
- Reset: hold sys_rst_n low with uart_rxd=1 → all outputs at reset values; release → no pulses for 10000 clk.
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first), stop=1 → uart_done one cycle at 3+217+3906 clk ±1 after the falling edge; uart_data=8'hA5; frame_err=0.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap → three uart_done pulses 4340 clk apart; data matches each byte.
- 0x3C sent with stop bit forced 0, then line high → one frame_err pulse; uart_data keeps the previous value; the next frame 0x81 is received correctly.
- 100-clk low glitch on idle line → START rejects it; no uart_done, no frame_err; rx_busy high ≤ 220 clk.
- Remote baud ±3 % (bit period 421 and 447 clk) sending 0xC3 → received correctly.
- Reset asserted at bit 4 of a frame → busy clears and no pulse; the following 0x12 frame is received correctly.
- With UART_RX_MAJORITY_EN, a 1-clk inverted spike at each data-bit centre of 0x96 → still received as 0x96.
